// File: rtl/sqrt_reconstruct.sv
// sqrt_reconstruct
//   Rebuilds a square-root radicand D = Q*Q + R from a root Q and remainder R
//   using a sequential shift-add multiplier.
//   The rebuilt value is compared against an expected radicand, and the
//   remainder is checked against the legal range R <= 2*Q.
//   Typical use is as an on-chip self-check behind the iterative sqrt unit.
//   It also works stand-alone as a small squarer.
//
// Ports
//   clk       in   system clock; all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   request pulse; sampled only while idle
//   Root      in   root Q; only Root[DW/2-1:0] is used
//   Reminder  in   remainder R (unsigned, already corrected)
//   Expected  in   radicand to compare against
//   Ready     out  one-cycle pulse when results are valid
//   Busy      out  high while loading or multiplying
//   Square    out  low DW bits of Q*Q + R
//   Overflow  out  Q*Q + R >= 2^DW
//   Match     out  no overflow and Square == Expected
//   Rem_ok    out  Reminder <= 2*Q
module sqrt_reconstruct #(
  parameter int DW = 16,
  parameter int CW = $clog2(DW/2) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] Root,
  input  logic [DW-1:0] Reminder,
  input  logic [DW-1:0] Expected,
  output logic          Ready,
  output logic          Busy,
  output logic [DW-1:0] Square,
  output logic          Overflow,
  output logic          Match,
  output logic          Rem_ok
);

  localparam int HW = DW / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0]   mcand_q, mcand_d;
  logic [HW-1:0] mplier_q, mplier_d;
  logic [DW:0]   acc_q, acc_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [HW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] square_q, square_d;
  logic          ovf_q, ovf_d;
  logic          match_q, match_d;
  logic          rem_ok_q, rem_ok_d;
  logic          ready_q, ready_d;

  // The upper half of Root is intentionally ignored.
  logic          unused_root_s;
  assign unused_root_s = ^Root[DW-1:HW];

  // 2*Q as a DW+1-bit value, used for the remainder range check.
  logic [DW:0]   two_q_s;
  assign two_q_s = {{HW{1'b0}}, q_q, 1'b0};

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    exp_d    = exp_q;
    q_d      = q_q;
    r_d      = r_q;
    square_d = square_q;
    ovf_d    = ovf_q;
    match_d  = match_q;
    rem_ok_d = rem_ok_q;
    ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = Root[HW-1:0];
          r_d     = Reminder;
          exp_d   = Expected;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // The remainder preloads the accumulator, so no separate add step is needed.
        mcand_d  = {{(HW + 1){1'b0}}, q_q};
        mplier_d = q_q;
        acc_d    = {1'b0, r_q};
        cnt_d    = {CW{1'b0}};
        state_d  = MUL;
      end
      MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + {{(CW - 1){1'b0}}, 1'b1};
        if (cnt_q == CW'(HW - 1)) begin
          state_d = DONE;
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
        square_d = acc_q[DW-1:0];
        ovf_d    = acc_q[DW];
        match_d  = (acc_q == {1'b0, exp_q});
        rem_ok_d = ({1'b0, r_q} <= two_q_s);
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      mcand_q  <= {(DW + 1){1'b0}};
      mplier_q <= {HW{1'b0}};
      acc_q    <= {(DW + 1){1'b0}};
      exp_q    <= {DW{1'b0}};
      q_q      <= {HW{1'b0}};
      r_q      <= {DW{1'b0}};
      square_q <= {DW{1'b0}};
      ovf_q    <= 1'b0;
      match_q  <= 1'b0;
      rem_ok_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      exp_q    <= exp_d;
      q_q      <= q_d;
      r_q      <= r_d;
      square_q <= square_d;
      ovf_q    <= ovf_d;
      match_q  <= match_d;
      rem_ok_q <= rem_ok_d;
      ready_q  <= ready_d;
    end
  end

  assign Ready    = ready_q;
  assign Busy     = (state_q == LOAD) || (state_q == MUL);
  assign Square   = square_q;
  assign Overflow = ovf_q;
  assign Match    = match_q;
  assign Rem_ok   = rem_ok_q;

endmodule

// File: tb/tb_sqrt_reconstruct.sv
module tb_sqrt_reconstruct;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] Root;
  logic [DW-1:0] Reminder;
  logic [DW-1:0] Expected;
  logic          Ready;
  logic          Busy;
  logic [DW-1:0] Square;
  logic          Overflow;
  logic          Match;
  logic          Rem_ok;

  int checks;
  int failures;

  sqrt_reconstruct #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Root     (Root),
    .Reminder (Reminder),
    .Expected (Expected),
    .Ready    (Ready),
    .Busy     (Busy),
    .Square   (Square),
    .Overflow (Overflow),
    .Match    (Match),
    .Rem_ok   (Rem_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] root;
    logic [15:0] rem;
    logic [15:0] expd;
    logic [15:0] sq;
    logic        ovf;
    logic        match;
    logic        remok;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model from the arithmetic definition.
  task automatic model(input logic [15:0] root, input logic [15:0] rem, input logic [15:0] expd,
                       output logic [15:0] sq, output logic ovf, output logic match,
                       output logic remok);
    longint q;
    longint d;
    q     = longint'(root) % 256;
    d     = q * q + longint'(rem);
    sq    = 16'(d % 65536);
    ovf   = (d >= 65536);
    match = (d == longint'(expd));
    remok = (longint'(rem) <= 2 * q);
  endtask

  // Issue one operation and wait for Ready; lat = edges from sampling edge to Ready.
  task automatic run_op(input logic [15:0] root, input logic [15:0] rem, input logic [15:0] expd,
                        output int lat, output logic busy0);
    @(negedge clk);
    Root     = root;
    Reminder = rem;
    Expected = expd;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    Root     = 16'($urandom);
    Reminder = 16'($urandom);
    Expected = 16'($urandom);
    busy0    = Busy;
    lat      = 0;
    while (!Ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [15:0] root, input logic [15:0] rem,
                          input logic [15:0] expd);
    logic [15:0] sq;
    logic        ovf, match, remok, busy0;
    int          lat;
    model(root, rem, expd, sq, ovf, match, remok);
    run_op(root, rem, expd, lat, busy0);
    if (lat >= 40) begin
      check({name, "_timeout"}, 32'(lat), 32'd10);
    end else begin
      check({name, "_lat"}, 32'(lat), 32'd10);
      check({name, "_sq"}, 32'(Square), 32'(sq));
      check({name, "_ovf"}, 32'(Overflow), 32'(ovf));
      check({name, "_match"}, 32'(Match), 32'(match));
      check({name, "_remok"}, 32'(Rem_ok), 32'(remok));
    end
  endtask

  initial begin
    int          lat;
    int          ready_cnt;
    int          t1;
    int          t2;
    logic        busy0;
    logic [15:0] rr;

    checks   = 0;
    failures = 0;
    start    = 1'b0;
    Root     = 16'd0;
    Reminder = 16'd0;
    Expected = 16'd0;

    vecs[0] = '{16'd10,   16'd0,     16'd100,   16'h0064, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{16'h00FF, 16'h01FE,  16'hFFFF,  16'hFFFF, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{16'h00FF, 16'h01FF,  16'hFFFF,  16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'd0,    16'd0,     16'd0,     16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{16'hAB05, 16'd3,     16'd28,    16'd28,   1'b0, 1'b1, 1'b1};
    vecs[5] = '{16'h0010, 16'd33,    16'h0121,  16'h0121, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'd3,    16'd1,     16'd11,    16'd10,   1'b0, 1'b0, 1'b1};

    // Reset then idle.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Ready) ready_cnt++;
      if (Busy) ready_cnt += 100;
    end
    check("idle_ready_busy", 32'(ready_cnt), 32'd0);
    check("rst_square", 32'(Square), 32'd0);
    check("rst_flags", {29'd0, Overflow, Match, Rem_ok}, 32'd0);

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].root, vecs[i].rem, vecs[i].expd, lat, busy0);
      check($sformatf("vec%0d_busy", i), 32'(busy0), 32'd1);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd10);
      check($sformatf("vec%0d_sq", i), 32'(Square), 32'(vecs[i].sq));
      check($sformatf("vec%0d_flags", i), {29'd0, Overflow, Match, Rem_ok},
            {29'd0, vecs[i].ovf, vecs[i].match, vecs[i].remok});
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 32'(Ready), 32'd0);
      check($sformatf("vec%0d_hold", i), 32'(Square), 32'(vecs[i].sq));
    end

    // start pulses during an operation are ignored.
    @(negedge clk);
    Root = 16'd12; Reminder = 16'd5; Expected = 16'd149; start = 1'b1;
    ready_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 6);
      Root = 16'd200; Reminder = 16'd7; Expected = 16'd1;
      if (Ready) begin
        ready_cnt++;
        check("ign_sq", 32'(Square), 32'd149);
        check("ign_match", 32'(Match), 32'd1);
      end
    end
    check("ign_ready_count", 32'(ready_cnt), 32'd1);

    // Reset in the middle of MUL aborts with no Ready.
    @(negedge clk);
    Root = 16'd7; Reminder = 16'd2; Expected = 16'd51; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ready_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (Ready) ready_cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_square", 32'(Square), 32'd0);
    check("abort_flags", {29'd0, Busy, Match, Rem_ok}, 32'd0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (Ready) ready_cnt++;
    end
    check("abort_no_ready", 32'(ready_cnt), 32'd0);
    check_op("after_abort", 16'd7, 16'd2, 16'd51);

    // start held high: back-to-back operations with one idle cycle.
    @(negedge clk);
    Root = 16'd9; Reminder = 16'd4; Expected = 16'd85; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (Ready && t1 < 0) t1 = c;
      else if (Ready && t2 < 0) t2 = c;
    end
    start = 1'b0;
    check("b2b_first", 32'(t1), 32'd10);
    check("b2b_gap", 32'(t2 - t1), 32'd11);
    repeat (15) @(negedge clk);

    // Sweep every root with a random legal remainder.
    for (int q = 0; q < 256; q++) begin
      rr = 16'($urandom_range(2 * q, 0));
      check_op($sformatf("sweep_q%0d", q), 16'(q) | 16'($urandom_range(255, 0) << 8), rr,
               16'(q * q) + rr);
    end

    // Fully random operands.
    for (int i = 0; i < 60; i++) begin
      check_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom),
               (i % 2 == 0) ? 16'($urandom) : 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt_reconstruct.md
Name: sqrt_reconstruct

Overview:
- Inverse-direction companion to the iterative square-root unit. It takes a root Q and a remainder R and rebuilds the radicand D = Q*Q + R with a sequential shift-add multiplier.
- It also compares the rebuilt value against an expected radicand and checks that the remainder is in range.
- Sits downstream of the sqrt block (fed by its Result/Reminder/Data) as an on-chip self-check, and is usable stand-alone as a small squarer.
- Shares the codebase's start/Ready handshake and DW parameterisation from mdr_pkg.

Parameters:
- DW, 16, datapath width; must be even. Root significant width is DW/2.
- CW, $clog2(DW/2)+1, iteration counter width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- Root  input  DW  root Q; only Root[DW/2-1:0] used, upper bits ignored
- Reminder  input  DW  remainder R, unsigned (already corrected, non-negative)
- Expected  input  DW  radicand to compare against
- Ready  output  1  one-cycle pulse, results valid
- Busy  output  1  high in LOAD/MUL states
- Square  output  DW  Q*Q + R, low DW bits
- Overflow  output  1  Q*Q + R >= 2^DW
- Match  output  1  no overflow and Square == Expected
- Rem_ok  output  1  Reminder <= 2*Q (legal sqrt remainder)

Behaviour:
- Reset (rst=1 at edge, any state): state=IDLE, counter=0, all internal registers 0. Outputs: Ready=0, Busy=0, Square=0, Overflow=0, Match=0, Rem_ok=0. Reset mid-operation aborts with no Ready pulse.
- Internal registers:
  - mcand: DW+1 bits, multiplicand, shifted left.
  - mplier: DW/2 bits, multiplier, shifted right.
  - acc: DW+1 bits.
  - exp_r, q_r, r_r: operand copies.
- FSM states: IDLE, LOAD, MUL, DONE.
- IDLE: Busy=0. On start=1, capture Root[DW/2-1:0], Reminder and Expected into q_r/r_r/exp_r, then go to LOAD. Inputs may change after the capture edge.
- LOAD (1 cycle):
  - mcand={0,q_r zero-extended}, mplier=q_r, acc={0,r_r}, counter=0, then go to MUL.
  - The remainder preloads the accumulator, so there is no separate add step.
- MUL (exactly DW/2 cycles, independent of operand value):
  - Each cycle: if mplier[0], acc <= acc + mcand (DW+1-bit add, carry kept in acc[DW]).
  - Then mcand <<= 1, mplier >>= 1, counter++.
  - Go to DONE when counter == DW/2-1 (after that cycle's update).
- DONE (1 cycle):
  - Register Square=acc[DW-1:0], Overflow=acc[DW], Match=(acc=={0,exp_r}), Rem_ok=(r_r <= 2*q_r, DW+1-bit compare).
  - Ready=1 for this cycle only, then go to IDLE.
- Latency: start sampled at edge k gives Ready high in the cycle following edge k+DW/2+2. For DW=16 that is 10 cycles start-to-Ready.
- Outputs Square/Overflow/Match/Rem_ok are registered and hold their values until the next DONE or reset.
- start while not in IDLE is ignored, with no queueing. start held high continuously produces back-to-back operations with one IDLE cycle between them.
- start and rst in the same cycle: reset wins.
- Arithmetic:
  - Max Q*Q = (2^(DW/2)-1)^2 fits in DW bits.
  - Overflow is only possible via R, since acc is one bit wider than Square.
  - Square wraps mod 2^DW when Overflow=1, and Match is forced to 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 -> all outputs 0, Busy=0, no Ready for 20 cycles.
- Root=10, Reminder=0, Expected=100 -> Ready exactly 10 cycles after start, Square=0x0064, Match=1, Overflow=0, Rem_ok=1.
- Root=0xFF, Reminder=0x01FE, Expected=0xFFFF -> Square=0xFFFF, Match=1, Overflow=0, Rem_ok=1. Then Root=0xFF, Reminder=0x01FF -> Square=0x0000, Overflow=1, Match=0, Rem_ok=0.
- Root=0, Reminder=0, Expected=0 -> same 10-cycle latency, Square=0, Match=1. Root=0xAB05 (upper byte ignored), Reminder=3, Expected=28 -> Square=28, Match=1.
- Pulse start again on cycles 3 and 6 of an operation with different operands -> ignored; the first operation's results are delivered, one Ready pulse only.
- Assert rst in cycle 5 of MUL -> no Ready, outputs 0 next cycle. A new start afterward completes normally. Randomised sweep: all Q<256 with R in [0,2Q] -> Match=1 against D=Q*Q+R.
